// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath/memory.
// The master modport is the controller's view; slave is the datapath's view.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic       retire;
    logic       trap;
    logic       trap_cause;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_control, retire, trap, trap_cause
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_control, retire, trap, trap_cause
    );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I core: sequences fetch, decode, execute,
// memory and writeback for lw/sw/R-type/beq, trapping on illegal opcodes or memory timeouts.
module multicycle_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_controller_if.master bus
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] WAIT_MAX  = 16'hFFFF;

    typedef enum logic [3:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_ALUWB,
        S_BEQ,
        S_TRAP
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        trap_cause_q, trap_cause_d;
    logic        wait_state;
    logic        mem_stall;
    logic        timeout_hit;

    // R-type ALU operation; unlisted funct3 values quietly fall back to add.
    function automatic logic [2:0] rtype_alu(input logic [2:0] f3, input logic b5);
        logic [2:0] ctl;
        ctl = ALU_ADD;
        case (f3)
            3'b000:  ctl = b5 ? ALU_SUB : ALU_ADD;
            3'b010:  ctl = ALU_SLT;
            3'b110:  ctl = ALU_OR;
            3'b111:  ctl = ALU_AND;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            wait_cnt_q   <= '0;
            trap_cause_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign wait_state  = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign mem_stall   = wait_state && !bus.mem_ready;
    // The stall cycle that would bring the count up to TIMEOUT_CYCLES is the last one allowed.
    assign timeout_hit = mem_stall && (wait_cnt_q >= WAIT_LAST);

    // Outside the waiting states the counter sits at zero, which gives the clear-on-entry.
    always_comb begin
        wait_cnt_d = '0;
        if (mem_stall) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 16'd1;
        end
    end

    // NOTE: every output and next-state term gets a default first so no latch is inferred.
    always_comb begin
        state_d         = state_q;
        trap_cause_d    = trap_cause_q;
        bus.mem_req     = 1'b0;
        bus.mem_write   = 1'b0;
        bus.adr_src     = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.alu_src_a   = 2'b00;
        bus.alu_src_b   = 2'b00;
        bus.result_src  = 2'b00;
        bus.alu_control = ALU_ADD;
        bus.retire      = 1'b0;
        bus.trap        = 1'b0;
        bus.trap_cause  = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                bus.mem_req    = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 1'b1;
                end
            end

            S_DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXECR;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d      = S_TRAP;
                        trap_cause_d = 1'b0;
                    end
                endcase
            end

            S_MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                state_d       = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end

            S_MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.adr_src = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 1'b1;
                end
            end

            S_MEMWB: begin
                bus.result_src = 2'b01;
                bus.reg_write  = 1'b1;
                bus.retire     = 1'b1;
                state_d        = S_FETCH;
            end

            S_MEMWRITE: begin
                bus.mem_req   = 1'b1;
                bus.mem_write = 1'b1;
                bus.adr_src   = 1'b1;
                if (bus.mem_ready) begin
                    bus.retire = 1'b1;
                    state_d    = S_FETCH;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 1'b1;
                end
            end

            S_EXECR: begin
                bus.alu_src_a   = 2'b10;
                bus.alu_control = rtype_alu(bus.funct3, bus.funct7b5);
                state_d         = S_ALUWB;
            end

            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.retire    = 1'b1;
                state_d       = S_FETCH;
            end

            S_BEQ: begin
                bus.alu_src_a   = 2'b10;
                bus.alu_control = ALU_SUB;
                bus.pc_write    = bus.zero;
                bus.retire      = 1'b1;
                state_d         = S_FETCH;
            end

            S_TRAP: begin
                bus.trap       = 1'b1;
                bus.trap_cause = trap_cause_q;
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the next-generation multi-cycle RV32I core. It replaces the single-cycle main/ALU decoder pair.
- Sequences one shared memory port, the register file, IR, PC and a single ALU across FETCH/DECODE/EXECUTE/MEM/WB steps.
- Supports lw, sw, R-type (add/sub/and/or/slt) and beq. Any other opcode, or a memory timeout, traps.
- Sits between the instruction register (op/funct fields), the ALU zero flag, the memory handshake and the datapath muxes/enables.

Parameters:
- TIMEOUT_CYCLES, 255: maximum consecutive cycles a memory access may wait for mem_ready before trapping. Range 1..65535.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  instruction opcode, from IR.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_write  out  1  request is a store; only ever asserted together with mem_req.
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  out  1  IR and OldPC load enable.
- pc_write  out  1  PC load enable.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  ALU A select: 00=PC, 01=OldPC, 10=rd1.
- alu_src_b  out  2  ALU B select: 00=rd2, 01=imm, 10=const 4.
- result_src  out  2  result select: 00=ALUOut, 01=read data, 10=ALU result.
- alu_control  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- retire  out  1  one-cycle pulse on the final cycle of each completed instruction.
- trap  out  1  high while in TRAP.
- trap_cause  out  1  0=illegal opcode, 1=memory timeout; valid while trap=1.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to BOOT, the wait counter clears and trap_cause clears.
  - Every output is 0 while rst_n=0. Reset asserted mid-instruction abandons the instruction immediately.
- Output timing:
  - Outputs are decoded combinationally from state.
  - ir_write, pc_write and retire may additionally depend on mem_ready and zero, as listed per state.
- Defaults: any output not listed for a state is 0.
- BOOT: all outputs 0 → FETCH unconditionally. The first fetch therefore starts one cycle after reset release.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_control=add, result_src=10.
  - If mem_ready=1: ir_write=1 and pc_write=1 (PC←PC+4), → DECODE. Otherwise stay.
- DECODE:
  - Outputs: alu_src_a=01, alu_src_b=01, add (branch target to ALUOut).
  - Next state by op: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 1100011 → BEQ; anything else → TRAP with trap_cause=0.
- MEMADR:
  - Outputs: alu_src_a=10, alu_src_b=01, add.
  - op=0000011 → MEMREAD; otherwise → MEMWRITE.
- MEMREAD:
  - Outputs: mem_req=1, adr_src=1.
  - If mem_ready=1 → MEMWB. Otherwise stay.
- MEMWB:
  - Outputs: result_src=01, reg_write=1, retire=1 → FETCH.
- MEMWRITE:
  - Outputs: mem_req=1, mem_write=1, adr_src=1.
  - If mem_ready=1: retire=1, → FETCH. Otherwise stay.
- EXECR:
  - Outputs: alu_src_a=10, alu_src_b=00 → ALUWB.
  - alu_control from funct3/funct7b5:
    - 000 with b5=1 → sub; 000 with b5=0 → add.
    - 010 → slt; 110 → or; 111 → and.
    - Any other funct3 → add (no trap).
- ALUWB:
  - Outputs: result_src=00, reg_write=1, retire=1 → FETCH.
- BEQ:
  - Outputs: alu_src_a=10, alu_src_b=00, sub, result_src=00, retire=1.
  - pc_write=zero → FETCH.
- TRAP:
  - Outputs: trap=1; all strobes and mem_req are 0.
  - Remains in TRAP until reset.
- Memory wait counter (16 bits):
  - Clears on entry to FETCH, MEMREAD and MEMWRITE, and on every cycle where mem_ready=1.
  - Increments on each cycle of those states where mem_ready=0.
  - If the counter reaches TIMEOUT_CYCLES with mem_ready still 0: → TRAP with trap_cause=1. mem_ready arriving in that same cycle takes priority (normal completion).
  - Counter saturates; no wrap.
- Ignored inputs:
  - mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
  - zero outside BEQ is ignored.
- Cycle counts with zero-wait memory:
  - lw 5, sw 4, R-type 4, beq 3 cycles.
  - Each wait cycle adds 1.

Test Plan:
- Release reset with mem_ready tied to 1 and op=0110011, funct3=000, funct7b5=1 → state sequence BOOT, FETCH, DECODE, EXECR, ALUWB. EXECR shows alu_control=001. ALUWB shows reg_write=1 and retire=1. Next FETCH follows.
- lw (op=0000011) with mem_ready low for 3 cycles in MEMREAD → mem_req=1 and adr_src=1 held for 4 cycles. Then MEMWB shows result_src=01 and reg_write=1. Total 8 cycles from FETCH to retire.
- beq (op=1100011) run twice, with zero=1 then zero=0 in BEQ → pc_write=1 once, then 0. retire=1 both times. alu_control=001 both times.
- op=1111111 fetched → DECODE transitions to TRAP. trap=1, trap_cause=0, all strobes 0 for 20+ cycles. rst_n pulse returns state to BOOT and clears trap.
- TIMEOUT_CYCLES=4 and mem_ready stuck at 0 in FETCH → TRAP after 4 wait cycles with trap_cause=1. Rerun with mem_ready=1 on the 4th wait cycle → normal DECODE.
- rst_n dropped during MEMWRITE wait → all outputs 0 immediately, without waiting for a clock edge. After release, mem_req first rises in the cycle after BOOT.
